// File: rtl/ex.sv
// EX stage: single-cycle ALU/MUL/branch-link/address generation plus a
// 32-cycle radix-2 restoring divider that stalls the front of the pipeline.
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ex_alusel,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_opv1,
  input  logic [31:0] ex_opv2,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_we,
  input  logic [31:0] ex_link_addr,
  input  logic [31:0] ex_mem_offset,
  input  logic        flush,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_waddr,
  output logic        wb_we,
  output logic [7:0]  mem_aluop,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_sdata,
  output logic        stall_req
);
  localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_ARITH = 3'd3,
                         SEL_MUL = 3'd4, SEL_DIV = 3'd5, SEL_JUMP = 3'd6, SEL_LS = 3'd7;
  localparam logic [7:0] EXE_NOP_OP = 8'h00,
                         OP_AND = 8'h01, OP_OR = 8'h02, OP_XOR = 8'h03,
                         OP_SLL = 8'h04, OP_SRL = 8'h05, OP_SRA = 8'h06,
                         OP_ADD = 8'h07, OP_SUB = 8'h08, OP_SLT = 8'h09, OP_SLTU = 8'h0a,
                         OP_MUL = 8'h0b, OP_MULH = 8'h0c, OP_MULHSU = 8'h0d, OP_MULHU = 8'h0e,
                         OP_DIV = 8'h0f, OP_DIVU = 8'h10, OP_REM = 8'h11, OP_REMU = 8'h12;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo, r_rem, r_dvs;
  logic        r_neg_q, r_neg_r, r_is_rem;

  logic        w_div_op, w_div_sgn, w_div_start, w_ok;
  logic [31:0] w_abs1, w_abs2, w_res, w_div_res;
  logic [32:0] w_shift, w_trial;
  logic        w_qbit;
  logic signed [32:0] w_ma, w_mb;
  logic signed [63:0] w_prod;

  assign w_div_op    = (ex_alusel == SEL_DIV) && (ex_aluop >= OP_DIV) && (ex_aluop <= OP_REMU);
  assign w_div_sgn   = (ex_aluop == OP_DIV) || (ex_aluop == OP_REM);
  assign w_div_start = (r_state == S_IDLE) && w_div_op && (ex_opv2 != 32'd0) && !flush;
  assign w_abs1      = (w_div_sgn && ex_opv1[31]) ? -ex_opv1 : ex_opv1;
  assign w_abs2      = (w_div_sgn && ex_opv2[31]) ? -ex_opv2 : ex_opv2;

  // Shift the partial remainder left by one, pulling in the next dividend bit;
  // bit 32 of the trial difference is the borrow (quotient bit = 0).
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_trial[32];
  assign w_div_res = r_is_rem ? (r_neg_r ? -r_rem : r_rem) : (r_neg_q ? -r_quo : r_quo);

  assign w_ma   = {(ex_aluop == OP_MULH || ex_aluop == OP_MULHSU) && ex_opv1[31], ex_opv1};
  assign w_mb   = {(ex_aluop == OP_MULH) && ex_opv2[31], ex_opv2};
  assign w_prod = 64'(w_ma) * 64'(w_mb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_div_start) begin
          r_quo    <= w_abs1;
          r_rem    <= '0;
          r_dvs    <= w_abs2;
          r_neg_q  <= w_div_sgn && (ex_opv1[31] ^ ex_opv2[31]);
          r_neg_r  <= w_div_sgn && ex_opv1[31];
          r_is_rem <= (ex_aluop == OP_REM) || (ex_aluop == OP_REMU);
          r_cnt    <= '0;
          r_state  <= S_BUSY;
        end
        S_BUSY: begin
          r_rem <= w_qbit ? w_trial[31:0] : w_shift[31:0];
          r_quo <= {r_quo[30:0], w_qbit};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_res = '0;
    w_ok  = 1'b1;
    case (ex_alusel)
      SEL_LOGIC: case (ex_aluop)
        OP_AND:  w_res = ex_opv1 & ex_opv2;
        OP_OR:   w_res = ex_opv1 | ex_opv2;
        OP_XOR:  w_res = ex_opv1 ^ ex_opv2;
        default: w_ok = 1'b0;
      endcase
      SEL_SHIFT: case (ex_aluop)
        OP_SLL:  w_res = ex_opv1 << ex_opv2[4:0];
        OP_SRL:  w_res = ex_opv1 >> ex_opv2[4:0];
        OP_SRA:  w_res = $unsigned($signed(ex_opv1) >>> ex_opv2[4:0]);
        default: w_ok = 1'b0;
      endcase
      SEL_ARITH: case (ex_aluop)
        OP_ADD:  w_res = ex_opv1 + ex_opv2;
        OP_SUB:  w_res = ex_opv1 - ex_opv2;
        OP_SLT:  w_res = {31'd0, $signed(ex_opv1) < $signed(ex_opv2)};
        OP_SLTU: w_res = {31'd0, ex_opv1 < ex_opv2};
        default: w_ok = 1'b0;
      endcase
      SEL_MUL: case (ex_aluop)
        OP_MUL:                       w_res = w_prod[31:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_prod[63:32];
        default:                      w_ok = 1'b0;
      endcase
      // Divide by zero resolves here without ever entering the iterative path.
      SEL_DIV: if (!w_div_op) w_ok = 1'b0;
               else if (ex_opv2 == 32'd0)
                 w_res = (ex_aluop == OP_REM || ex_aluop == OP_REMU) ? ex_opv1 : 32'hFFFF_FFFF;
      SEL_JUMP: w_res = ex_link_addr;
      SEL_LS:   w_res = '0;
      default:  w_ok = 1'b0;
    endcase
    if (r_state == S_DONE) begin
      w_res = w_div_res;
      w_ok  = 1'b1;
    end
  end

  assign stall_req = !rst && !flush && (w_div_start || r_state == S_BUSY);
  assign wb_wdata  = (!rst && w_ok && r_state != S_BUSY && !w_div_start) ? w_res : 32'd0;
  assign wb_waddr  = rst ? 5'd0 : ex_waddr;
  assign wb_we     = !rst && !flush && ex_we && w_ok && r_state != S_BUSY;
  assign mem_aluop = (!rst && ex_alusel == SEL_LS) ? ex_aluop : EXE_NOP_OP;
  assign mem_addr  = (!rst && ex_alusel == SEL_LS) ? ex_opv1 + ex_mem_offset : 32'd0;
  assign mem_sdata = (!rst && ex_alusel == SEL_LS) ? ex_opv2 : 32'd0;
endmodule

// File: tb/tb_ex.sv
// Directed + random bench for the EX stage against a behavioural model.
module tb_ex;
  localparam logic [2:0] S_NOP = 3'd0, S_LOG = 3'd1, S_SH = 3'd2, S_AR = 3'd3,
                         S_MUL = 3'd4, S_DIV = 3'd5, S_JMP = 3'd6, S_LS = 3'd7;
  localparam logic [7:0] O_AND = 8'h01, O_OR = 8'h02, O_XOR = 8'h03, O_SLL = 8'h04,
                         O_SRL = 8'h05, O_SRA = 8'h06, O_ADD = 8'h07, O_SUB = 8'h08,
                         O_SLT = 8'h09, O_SLTU = 8'h0a, O_MUL = 8'h0b, O_MULH = 8'h0c,
                         O_MULHSU = 8'h0d, O_MULHU = 8'h0e, O_DIV = 8'h0f, O_DIVU = 8'h10,
                         O_REM = 8'h11, O_REMU = 8'h12, O_SW = 8'h20, O_JAL = 8'h30;

  logic        clk = 0, rst = 1, flush = 0;
  logic [2:0]  ex_alusel = 0;
  logic [7:0]  ex_aluop = 0;
  logic [31:0] ex_opv1 = 0, ex_opv2 = 0, ex_link_addr = 0, ex_mem_offset = 0;
  logic [4:0]  ex_waddr = 0;
  logic        ex_we = 0;
  logic [31:0] wb_wdata, mem_addr, mem_sdata;
  logic [4:0]  wb_waddr;
  logic        wb_we, stall_req;
  logic [7:0]  mem_aluop;
  int n_chk = 0, n_fail = 0;

  ex dut (.clk(clk), .rst(rst), .ex_alusel(ex_alusel), .ex_aluop(ex_aluop), .ex_opv1(ex_opv1),
          .ex_opv2(ex_opv2), .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_link_addr(ex_link_addr),
          .ex_mem_offset(ex_mem_offset), .flush(flush), .wb_wdata(wb_wdata), .wb_waddr(wb_waddr),
          .wb_we(wb_we), .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
          .stall_req(stall_req));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {write-enable-valid, result} from the ISA definition with 64-bit arithmetic.
  function automatic logic [32:0] ref_wb(input logic [2:0] s, input logic [7:0] o,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lk);
    longint sa, sb;
    longint unsigned ua, ub, p;
    logic [31:0] r;
    logic ok;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    r = 0; ok = 1;
    case (s)
      S_LOG: if (o == O_AND) r = a & b; else if (o == O_OR) r = a | b;
             else if (o == O_XOR) r = a ^ b; else ok = 0;
      S_SH:  if (o == O_SLL) r = 32'(ua << b[4:0]); else if (o == O_SRL) r = 32'(ua >> b[4:0]);
             else if (o == O_SRA) r = 32'(sa >>> b[4:0]); else ok = 0;
      S_AR:  if (o == O_ADD) r = 32'(ua + ub); else if (o == O_SUB) r = 32'(ua - ub);
             else if (o == O_SLT) r = (sa < sb) ? 1 : 0; else if (o == O_SLTU) r = (ua < ub) ? 1 : 0;
             else ok = 0;
      S_MUL: begin
        if (o == O_MUL || o == O_MULHU) p = ua * ub;
        else if (o == O_MULH) p = longint'(sa * sb);
        else p = longint'(sa * longint'(ub));
        if (o == O_MUL) r = p[31:0];
        else if (o >= O_MULH && o <= O_MULHU) r = p[63:32];
        else ok = 0;
      end
      S_DIV: begin
        if (b == 0) r = (o == O_REM || o == O_REMU) ? a : 32'hFFFF_FFFF;
        else if (o == O_DIV)  r = 32'(sa / sb);
        else if (o == O_REM)  r = 32'(sa % sb);
        else if (o == O_DIVU) r = 32'(ua / ub);
        else if (o == O_REMU) r = 32'(ua % ub);
        if (o < O_DIV || o > O_REMU) begin r = 0; ok = 0; end
      end
      S_JMP: r = lk;
      S_LS:  r = 0;
      default: ok = 0;
    endcase
    if (!ok) r = 0;
    return {ok, r};
  endfunction

  task automatic drive(input logic [2:0] s, input logic [7:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] off);
    ex_alusel = s; ex_aluop = o; ex_opv1 = a; ex_opv2 = b; ex_mem_offset = off;
    ex_we = 1; ex_waddr = 5'($urandom); ex_link_addr = $urandom;
  endtask

  // Starts a divide from just after an edge, scrambles operands while it runs,
  // and checks the 33-cycle stall window plus the final result.
  task automatic run_div(input string tag, input logic [7:0] o, input logic [31:0] a,
                         input logic [31:0] b);
    logic [32:0] e;
    int cyc;
    e = ref_wb(S_DIV, o, a, b, 0);
    cyc = 0;
    drive(S_DIV, o, a, b, 0);
    #1;
    while (stall_req === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
      ex_opv1 = $urandom; ex_opv2 = $urandom;
      #1;
    end
    chk({tag, " stall cycles"}, cyc, (b != 0) ? 33 : 0);
    chk({tag, " result"}, wb_wdata, e[31:0]);
    chk({tag, " we"}, {31'd0, wb_we}, 32'd1);
    ex_alusel = S_NOP;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] sels [14];
    logic [7:0] ops  [14];
    logic [32:0] e;
    logic [31:0] a, b, off;
    int k;
    sels = '{S_LOG, S_LOG, S_LOG, S_SH, S_SH, S_SH, S_AR, S_AR, S_AR, S_AR, S_MUL, S_JMP, S_LS, S_NOP};
    ops  = '{O_AND, O_OR, O_XOR, O_SLL, O_SRL, O_SRA, O_ADD, O_SUB, O_SLT, O_SLTU, O_MUL, O_JAL, O_SW, O_ADD};

    // Reset holds every output at zero regardless of inputs.
    drive(S_LS, O_SW, 32'h1000, 32'h55, 32'h8);
    #1;
    chk("rst wb_wdata", wb_wdata, 0);
    chk("rst wb_we", {31'd0, wb_we}, 0);
    chk("rst mem_aluop", {24'd0, mem_aluop}, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_sdata", mem_sdata, 0);
    chk("rst stall", {31'd0, stall_req}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    drive(S_AR, O_ADD, 32'hFFFF_FFFF, 32'd1, 0);
    #1;
    chk("add wrap", wb_wdata, 0);
    chk("add stall", {31'd0, stall_req}, 0);

    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      k = $urandom_range(13);
      a = $urandom; b = (i % 4 == 0) ? 32'h8000_0000 : $urandom; off = $urandom;
      if (i == 5) ops[10] = O_MULH;
      if (i == 20) ops[10] = O_MULHSU;
      if (i == 40) ops[10] = O_MULHU;
      if (i == 50) ops[0] = 8'h77;  // unknown op inside a known class
      drive(sels[k], ops[k], a, b, off);
      #1;
      e = ref_wb(sels[k], ops[k], a, b, ex_link_addr);
      chk("rand wdata", wb_wdata, e[31:0]);
      chk("rand we", {31'd0, wb_we}, {31'd0, e[32]});
      chk("rand waddr", {27'd0, wb_waddr}, {27'd0, ex_waddr});
      chk("rand mem_addr", mem_addr, (sels[k] == S_LS) ? a + off : 32'd0);
      chk("rand stall", {31'd0, stall_req}, 0);
    end
    @(posedge clk); #1;

    run_div("div -7/2", O_DIV, -32'sd7, 32'd2);
    run_div("rem -7/2", O_REM, -32'sd7, 32'd2);
    run_div("divu 100/0", O_DIVU, 32'd100, 32'd0);
    run_div("remu 100/0", O_REMU, 32'd100, 32'd0);
    run_div("div ovf", O_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("rem ovf", O_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++)
      run_div("div rand", O_DIV + 8'(i % 4), $urandom, (i == 3) ? 32'd3 : $urandom);

    // Flush at busy counter 10 (cycle N+11).
    drive(S_DIV, O_DIVU, 32'd1000, 32'd7, 0);
    repeat (11) @(posedge clk);
    #1;
    chk("flush busy before", {31'd0, stall_req}, 1);
    flush = 1;
    #1;
    chk("flush stall", {31'd0, stall_req}, 0);
    chk("flush we", {31'd0, wb_we}, 0);
    @(posedge clk); #1;
    flush = 0;
    drive(S_AR, O_ADD, 32'd5, 32'd6, 0);
    #1;
    chk("post-flush add", wb_wdata, 32'd11);
    chk("post-flush stall", {31'd0, stall_req}, 0);
    @(posedge clk); #1;

    // Reset in the middle of a divide.
    drive(S_DIV, O_DIV, 32'd12345, 32'd17, 0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("midrst stall", {31'd0, stall_req}, 0);
    chk("midrst wdata", wb_wdata, 0);
    chk("midrst we", {31'd0, wb_we}, 0);
    @(posedge clk); #1;
    rst = 0;
    drive(S_LS, O_SW, 32'h1000, 32'hCAFE, 32'd8);
    ex_we = 0;
    #1;
    chk("sw mem_addr", mem_addr, 32'h1008);
    chk("sw mem_aluop", {24'd0, mem_aluop}, {24'd0, O_SW});
    chk("sw mem_sdata", mem_sdata, 32'hCAFE);
    chk("sw stall", {31'd0, stall_req}, 0);
    @(posedge clk); #1;
    run_div("div after rst", O_DIV, 32'd12345, 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
